// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the wait-state memory responder.
package mem_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 8;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT    = 2'b01,
    S_RESP    = 2'b10,
    S_RELEASE = 2'b11
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_storage_array.sv
// Word array for the memory responder: synchronous write, combinational read.
module mem_storage_array #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wword,
  output logic [WORD_W-1:0] rword
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wword;
  end

  assign rword = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory responder with programmable wait states and a one-cycle ready pulse.
// Optional per-word even parity is enabled by defining MEM_PARITY_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_PARITY_EN
  input  logic              par_flip_inject,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic              req;
  logic              capture;

  op_t               op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              illegal_q;

  logic              we;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic              par_err;

  assign req     = mem_read | mem_write;
  assign capture = (state == S_IDLE) && req;
  assign busy    = (state != S_IDLE);

  // Request fields are frozen at capture so later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (capture) begin
      op_q      <= mem_write ? OP_WR : OP_RD;
      idx_q     <= addr[IDX_W-1:0];
      wdata_q   <= wdata;
      illegal_q <= (mem_read & mem_write) | ({1'b0, addr} >= DEPTH_L);
    end
  end

`ifdef MEM_PARITY_EN
  logic flip_q;

  always_ff @(posedge clk) begin
    if (capture) flip_q <= par_flip_inject;
  end

  assign wr_word = {(^wdata_q) ^ flip_q, wdata_q};
  assign par_err = (op_q == OP_RD) && ((^rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
`else
  assign wr_word = wdata_q;
  assign par_err = 1'b0;
`endif

  assign we = (state == S_RESP) && (op_q == OP_WR) && !illegal_q;

  mem_storage_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (idx_q),
    .wword (wr_word),
    .rword (rd_word)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (req) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:    if (wait_cnt <= 4'd1) state_next = S_RESP;
      S_RESP:    state_next = S_RELEASE;
      S_RELEASE: if (!req) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Response outputs are registered on the S_RESP edge, giving a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      rdata     <= '0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      mem_ready <= (state == S_RESP);
      err       <= (state == S_RESP) && (illegal_q || par_err);
      case (state)
        S_IDLE: if (req) wait_cnt <= WAIT_INIT;
        S_WAIT: wait_cnt <= wait_cnt - 4'd1;
        S_RESP: begin
          if (illegal_q)           rdata <= '0;
          else if (op_q == OP_RD)  rdata <= rd_word[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic        read0 = 1'b0, write0 = 1'b0;
  logic        flip = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, rdata0;
  logic        mem_ready, busy, err;
  logic        ready0, busy0, err0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(128), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata),
`ifdef MEM_PARITY_EN
    .par_flip_inject(flip),
`endif
    .rdata(rdata), .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(128), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_read(read0), .mem_write(write0),
    .addr(addr), .wdata(wdata),
`ifdef MEM_PARITY_EN
    .par_flip_inject(flip),
`endif
    .rdata(rdata0), .mem_ready(ready0), .busy(busy0), .err(err0)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input bit which, input bit rd, input bit wr,
                               input logic [7:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    if (which) begin read0 = rd; write0 = wr; end
    else       begin mem_read = rd; mem_write = wr; end
  endtask

  // Latency = clock edges from the capture edge to the edge that raises mem_ready; -1 on timeout.
  task automatic wait_ready(input bit which, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((which ? ready0 : mem_ready) === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", mem_ready); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy0: got %b expected 0", busy0); end
    reset = 1'b0;
  endtask

  task automatic test_write_read;
    int lat;
    @(negedge clk);
    applyStimulus(0, 0, 1, 8'h10, 32'hDEADBEEF);
    wait_ready(0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL wr_latency: got %0d expected 3", lat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_err: got %b expected 0", err); end
    applyStimulus(0, 0, 0, 8'h10, 32'h0);
    @(negedge clk);
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_pulse_width: got %b expected 0", mem_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_release: got %b expected 0", busy); end
    applyStimulus(0, 1, 0, 8'h10, 32'h0);
    wait_ready(0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL rd_latency: got %0d expected 3", lat); end
    n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL rd_data: got %h expected deadbeef", rdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_err: got %b expected 0", err); end
    applyStimulus(0, 0, 0, 8'h10, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_held_strobe;
    int pulses = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1, 0, 8'h10, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) pulses++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("[TB] FAIL held_pulses: got %0d expected 1", pulses); end
    n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL held_busy: got %b expected 1", busy_ok); end
    applyStimulus(0, 0, 0, 8'h10, 32'h0);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL held_release: got %b expected 0", busy); end
  endtask

  task automatic test_illegal;
    int lat;
    @(negedge clk);
    applyStimulus(0, 1, 0, 8'hC8, 32'h0);
    wait_ready(0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL oob_latency: got %0d expected 3", lat); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_err: got %b expected 1", err); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL oob_rdata: got %h expected 0", rdata); end
    applyStimulus(0, 0, 0, 8'h0, 32'h0);
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL oob_err_width: got %b expected 0", err); end
    applyStimulus(0, 0, 1, 8'h05, 32'h55AA55AA);
    wait_ready(0, lat);
    applyStimulus(0, 0, 0, 8'h05, 32'h0);
    @(negedge clk);
    applyStimulus(0, 1, 1, 8'h05, 32'h11111111);
    wait_ready(0, lat);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL both_err: got %b expected 1", err); end
    applyStimulus(0, 0, 0, 8'h05, 32'h0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 8'h05, 32'h0);
    wait_ready(0, lat);
    n_checks++; if (rdata !== 32'h55AA55AA) begin n_fail++; $display("[TB] FAIL both_nowrite: got %h expected 55aa55aa", rdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL both_readback_err: got %b expected 0", err); end
    applyStimulus(0, 0, 0, 8'h05, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    int lat;
    @(negedge clk);
    applyStimulus(0, 0, 1, 8'h20, 32'hAAAAAAAA);
    wait_ready(0, lat);
    applyStimulus(0, 0, 0, 8'h20, 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 1, 8'h20, 32'h12345678);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy_after: got %b expected 0", busy); end
    reset = 1'b0;
    applyStimulus(0, 0, 0, 8'h20, 32'h0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 8'h20, 32'h0);
    wait_ready(0, lat);
    n_checks++; if (rdata !== 32'hAAAAAAAA) begin n_fail++; $display("[TB] FAIL abort_data: got %h expected aaaaaaaa", rdata); end
    applyStimulus(0, 0, 0, 8'h20, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_zero_wait;
    int lat;
    @(negedge clk);
    applyStimulus(1, 0, 1, 8'h10, 32'hCAFEF00D);
    wait_ready(1, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL ws0_wr_latency: got %0d expected 1", lat); end
    applyStimulus(1, 0, 0, 8'h10, 32'h0);
    @(negedge clk);
    applyStimulus(1, 1, 0, 8'h10, 32'h0);
    wait_ready(1, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL ws0_rd_latency: got %0d expected 1", lat); end
    n_checks++; if (rdata0 !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL ws0_rd_data: got %h expected cafef00d", rdata0); end
    applyStimulus(1, 0, 0, 8'h10, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [7:0]  a;
    logic [31:0] d;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a = 8'h40 + 8'(i);
      d = 32'h0000_0100 + 32'(i * 3);
      applyStimulus(1, 0, 1, a, d);
      wait_ready(1, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL b2b_wr_latency[%0d]: got %0d expected 1", i, lat); end
      applyStimulus(1, 0, 0, a, 32'h0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      a = 8'h40 + 8'(i);
      d = 32'h0000_0100 + 32'(i * 3);
      applyStimulus(1, 1, 0, a, 32'h0);
      wait_ready(1, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL b2b_rd_latency[%0d]: got %0d expected 1", i, lat); end
      n_checks++; if (rdata0 !== d) begin n_fail++; $display("[TB] FAIL b2b_rd_data[%0d]: got %h expected %h", i, rdata0, d); end
      applyStimulus(1, 0, 0, a, 32'h0);
      @(negedge clk);
    end
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity;
    int lat;
    @(negedge clk);
    flip = 1'b1;
    applyStimulus(0, 0, 1, 8'h30, 32'h00000001);
    wait_ready(0, lat);
    flip = 1'b0;
    applyStimulus(0, 0, 0, 8'h30, 32'h0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 8'h30, 32'h0);
    wait_ready(0, lat);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL par_inject_err: got %b expected 1", err); end
    n_checks++; if (rdata !== 32'h00000001) begin n_fail++; $display("[TB] FAIL par_inject_data: got %h expected 00000001", rdata); end
    applyStimulus(0, 0, 0, 8'h30, 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 1, 8'h31, 32'h00000007);
    wait_ready(0, lat);
    applyStimulus(0, 0, 0, 8'h31, 32'h0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 8'h31, 32'h0);
    wait_ready(0, lat);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL par_clean_err: got %b expected 0", err); end
    n_checks++; if (rdata !== 32'h00000007) begin n_fail++; $display("[TB] FAIL par_clean_data: got %h expected 00000007", rdata); end
    applyStimulus(0, 0, 0, 8'h31, 32'h0);
    @(negedge clk);
  endtask
`endif

  initial begin
    $display("[TB] starting mem_responder bench");
    test_reset;
    test_write_read;
    test_held_strobe;
    test_illegal;
    test_reset_mid_write;
    test_zero_wait;
    test_back_to_back;
`ifdef MEM_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
